// File: rtl/pipe_scheduler_if.sv
// Signal bundle between the game input/timing logic (master) and pipe_scheduler (slave).
interface pipe_scheduler_if;
   logic       key_press;
   logic       game_tick;
   logic       start;
   logic       collision;
   logic [7:0] x;
   logic [6:0] y;
   logic       running;
   logic [4:0] fifo_count;
   logic [7:0] score;

   modport master (
      output key_press, game_tick, start, collision,
      input  x, y, running, fifo_count, score
   );

   modport slave (
      input  key_press, game_tick, start, collision,
      output x, y, running, fifo_count, score
   );
endinterface

// File: rtl/pipe_scheduler.sv
// Scrolling-pipe sequencer: gap-Y FIFO fed by an LFSR on key presses, pipe X stepping/respawn,
// and the IDLE/RUN/RESPAWN/OVER game FSM. Define PIPE_SCHED_SCORE_EN to build the score counter.
module pipe_scheduler #(
   parameter int unsigned DEPTH     = 10,
   parameter logic [7:0]  X_START   = 8'd160,
   parameter logic [6:0]  Y_DEFAULT = 7'd50,
   parameter logic [6:0]  Y_MIN     = 7'd10,
   parameter logic [7:0]  BIRD_X    = 8'd40
) (
   input logic             CLOCK_50,
   input logic             reset,
   pipe_scheduler_if.slave bus
);
   localparam int unsigned PW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, RESPAWN, OVER} state_t;

   state_t        state_q, state_d;
   logic [7:0]    x_q, x_d;
   logic [6:0]    y_q, y_d;
   logic          armed_q, armed_d;
   logic          running_q;
   logic [6:0]    lfsr_q;
   logic          keyPrev_q;
   logic [6:0]    mem_q [DEPTH];
   logic [PW-1:0] wrPtr_q, rdPtr_q;
   logic [4:0]    count_q;
   logic          pop;
   logic          push;
   logic          keyEdge;
   logic [6:0]    pushValue;

   assign keyEdge   = bus.key_press & ~keyPrev_q;
   assign pushValue = {1'b0, lfsr_q[5:0]} + Y_MIN;
   // A full FIFO still takes a push when the same cycle pops, since a slot frees up.
   assign push      = keyEdge && ((count_q != 5'(DEPTH)) || pop);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      armed_d = armed_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) state_d = RUN;
         end
         RUN: begin
            if (bus.collision) begin
               state_d = OVER;
               armed_d = 1'b0;
            end else if (bus.game_tick) begin
               if (x_q == 8'd0) state_d = RESPAWN;
               else             x_d = x_q - 8'd1;
            end
         end
         RESPAWN: begin
            state_d = RUN;
            x_d     = X_START;
            if (count_q != 5'd0) begin
               y_d = mem_q[rdPtr_q];
               pop = 1'b1;
            end else begin
               y_d = Y_DEFAULT;
            end
         end
         OVER: begin
            // Leaving OVER needs start to be seen low first, so a held start cannot restart.
            if (!bus.start) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               state_d = IDLE;
               x_d     = X_START;
               y_d     = Y_DEFAULT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q   <= IDLE;
         x_q       <= X_START;
         y_q       <= Y_DEFAULT;
         armed_q   <= 1'b0;
         running_q <= 1'b0;
         lfsr_q    <= 7'h5A;
         keyPrev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         armed_q   <= armed_d;
         running_q <= (state_d == RUN) || (state_d == RESPAWN);
         lfsr_q    <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
         keyPrev_q <= bus.key_press;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= 5'd0;
      end else begin
         if (push) wrPtr_q <= (wrPtr_q == PW'(DEPTH - 1)) ? '0 : wrPtr_q + PW'(1);
         if (pop)  rdPtr_q <= (rdPtr_q == PW'(DEPTH - 1)) ? '0 : rdPtr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + 5'd1;
            2'b01:   count_q <= count_q - 5'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (push) mem_q[wrPtr_q] <= pushValue;
   end

`ifdef PIPE_SCHED_SCORE_EN
   logic [7:0] score_q;
   logic       scoreInc;
   logic       scoreClr;

   assign scoreClr = (state_q == IDLE) && bus.start;
   assign scoreInc = (state_q == RUN) && !bus.collision && bus.game_tick && (x_q == BIRD_X);

   always_ff @(posedge CLOCK_50) begin
      if (reset)                              score_q <= 8'd0;
      else if (scoreClr)                      score_q <= 8'd0;
      else if (scoreInc && score_q != 8'hFF)  score_q <= score_q + 8'd1;
   end

   assign bus.score = score_q;
`else
   assign bus.score = 8'd0;
`endif

   assign bus.x          = x_q;
   assign bus.y          = y_q;
   assign bus.running    = running_q;
   assign bus.fifo_count = count_q;
endmodule
